// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
//   PS/2 device-to-host receiver that runs entirely in the system clock
//   domain, with a show-ahead FIFO on its output. Raw ps2_clk/ps2_data are
//   synchronised. Falling edges of the synchronised clock are detected from a
//   registered copy. 11-bit frames are assembled: start, DATA_BITS data bits
//   sent LSB first, odd parity, then stop. Each frame is checked, and good
//   bytes are pushed into the FIFO. A partial frame is dropped when the bus
//   stalls for TIMEOUT_CYC clocks.
//
// Optional build macro:
//   PS2_GLITCH_FILTER_EN - the synchronised ps2_clk passes a stability filter
//                          before edge detection. The filtered level changes
//                          only after FILTER_LEN consecutive samples at the
//                          new level. This adds FILTER_LEN clocks to the
//                          edge-detect latency.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   ps2_clk      in   raw PS/2 clock (asynchronous)
//   ps2_data     in   raw PS/2 data (asynchronous)
//   rd_en        in   pop the head entry (ignored while empty)
//   rd_data      out  FIFO head; valid while rd_valid, 0 when empty
//   rd_valid     out  FIFO not empty
//   fifo_count   out  FIFO occupancy
//   parity_err   out  1-clk pulse: bad parity, frame dropped
//   frame_err    out  1-clk pulse: stop bit 0 or timeout, frame dropped
//   overflow     out  1-clk pulse: good frame dropped because FIFO full
//   o_dbg_state  out  receiver FSM state (IDLE=0, DATA=1, PARITY=2, STOP=3)
//
// Read handshake: rd_valid/rd_data show the oldest byte. A pop happens on
// every clock edge where rd_en && rd_valid. rd_data then moves to the next
// entry after that edge. rd_en while !rd_valid has no effect.
// ---------------------------------------------------------------------------
module ps2_rx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 8,     // power of 2, >= 2
  parameter int SYNC_STAGES = 2,     // >= 2
  parameter int TIMEOUT_CYC = 5000,
  parameter int FILTER_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [1:0]                    o_dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // -------------------------------------------------------------------------
  // Input synchronisers. They reset to 1 (idle bus) so that reset release
  // does not look like a falling edge.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   w_clk_sync;
  logic                   w_dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign w_clk_sync = r_clk_sync[SYNC_STAGES-1];
  assign w_dat      = r_dat_sync[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Clock level used for edge detection (optionally glitch filtered).
  // -------------------------------------------------------------------------
  logic w_clk_level;

`ifdef PS2_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [FW-1:0] r_filt_cnt;
  logic          r_filt_clk;

  // The counter counts consecutive samples that differ from the current
  // filtered level. Any sample that agrees with the level restarts the count,
  // so pulses shorter than FILTER_LEN clocks never reach the edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt_cnt <= '0;
      r_filt_clk <= 1'b1;
    end else if (w_clk_sync == r_filt_clk) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
      r_filt_cnt <= '0;
      r_filt_clk <= w_clk_sync;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_clk_level = r_filt_clk;
`else
  logic w_unused_filter_len;
  assign w_unused_filter_len = (FILTER_LEN > 0);
  assign w_clk_level         = w_clk_sync;
`endif

  // -------------------------------------------------------------------------
  // Falling-edge detect. Data is sampled in the same cycle that w_fall is
  // high.
  // -------------------------------------------------------------------------
  logic r_clk_prev;
  logic w_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_clk_prev <= 1'b1;
    else       r_clk_prev <= w_clk_level;
  end

  assign w_fall = r_clk_prev & ~w_clk_level;

  // -------------------------------------------------------------------------
  // Frame receiver FSM
  // -------------------------------------------------------------------------
  logic [1:0]           r_state;
  logic [BW-1:0]        r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [TW-1:0]        r_to_cnt;

  logic w_timeout;
  logic w_stop_eval;
  logic w_par_ok;
  logic w_push;
  logic w_perr;
  logic w_ferr;

  // The timeout can only fire on a cycle with no falling edge. This keeps it
  // apart from the stop-bit check, so at most one error is raised per frame.
  assign w_timeout   = (r_state != ST_IDLE) && !w_fall &&
                       (r_to_cnt == TW'(TIMEOUT_CYC - 1));
  assign w_stop_eval = (r_state == ST_STOP) && w_fall;
  assign w_par_ok    = ((^r_shift) ^ r_par) == 1'b1;
  assign w_push      = w_stop_eval &  w_par_ok & w_dat;
  assign w_perr      = w_stop_eval & ~w_par_ok;
  assign w_ferr      = (w_stop_eval & w_par_ok & ~w_dat) | w_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
    end else if (w_timeout) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
    end else if (w_fall) begin
      case (r_state)
        ST_IDLE: begin
          // A high start bit is treated as noise on an idle bus.
          if (!w_dat) begin
            r_state  <= ST_DATA;
            r_bitcnt <= '0;
          end
        end
        ST_DATA: begin
          // LSB arrives first: shift in at the MSB and move right.
          r_shift  <= {w_dat, r_shift[DATA_BITS-1:1]};
          r_bitcnt <= r_bitcnt + 1'b1;
          if (r_bitcnt == BW'(DATA_BITS - 1)) r_state <= ST_PARITY;
        end
        ST_PARITY: begin
          r_par   <= w_dat;
          r_state <= ST_STOP;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_bitcnt <= '0;
        end
      endcase
    end
  end

  // Counts clocks since the last falling edge while a frame is in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          r_to_cnt <= '0;
    else if (r_state == ST_IDLE || w_fall || w_timeout) r_to_cnt <= '0;
    else                                                r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign o_dbg_state = r_state;

  // -------------------------------------------------------------------------
  // Show-ahead FIFO
  // -------------------------------------------------------------------------
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_ovf;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = rd_en & ~w_empty;
  // When the FIFO is full, a pop in the same cycle frees the slot being
  // written. The write targets the head location, which is read out this
  // cycle before the edge overwrites it.
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_ovf   = w_push &  w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  // Pointer width equals log2(depth), so the increments wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_valid   = ~w_empty;
  assign rd_data    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_count = r_count;

  // -------------------------------------------------------------------------
  // Registered status pulses
  // -------------------------------------------------------------------------
  logic r_parity_err;
  logic r_frame_err;
  logic r_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_parity_err <= w_perr;
      r_frame_err  <= w_ferr;
      r_overflow   <= w_ovf;
    end
  end

  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_fifo
//   Directed bench for ps2_rx_fifo. u_dut_a uses the default parameters.
//   u_dut_b uses FIFO_DEPTH=4 for the overflow cases. Both DUTs share the
//   PS/2 lines and reset, and each has its own rd_en. The PS/2 bit period is
//   40 clk: 20 clk high, then 20 clk low.
// ---------------------------------------------------------------------------
module tb_ps2_rx_fifo;

  localparam int TIMEOUT_CYC = 5000;
`ifdef PS2_GLITCH_FILTER_EN
  localparam int EDGE_LAT = 2 + 4;   // sync stages + filter length
`else
  localparam int EDGE_LAT = 2;       // sync stages
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_data;
  logic rd_en_a;
  logic rd_en_b;

  always #5 clk = ~clk;

  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_valid_a, rd_valid_b;
  logic [3:0] fifo_count_a;
  logic [2:0] fifo_count_b;
  logic       parity_err_a, frame_err_a, overflow_a;
  logic       parity_err_b, frame_err_b, overflow_b;
  logic [1:0] dbg_state_a, dbg_state_b;

  ps2_rx_fifo u_dut_a (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .fifo_count(fifo_count_a), .parity_err(parity_err_a),
    .frame_err(frame_err_a), .overflow(overflow_a), .o_dbg_state(dbg_state_a)
  );

  ps2_rx_fifo #(.FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .fifo_count(fifo_count_b), .parity_err(parity_err_b),
    .frame_err(frame_err_b), .overflow(overflow_b), .o_dbg_state(dbg_state_b)
  );

  // ---------------- pulse counters (cycles high) ----------------
  int perr_a_cnt = 0;
  int ferr_a_cnt = 0;
  int ovf_b_cnt  = 0;
  int perr_base, ferr_base, ovf_base;

  always @(posedge clk) begin
    if (parity_err_a) perr_a_cnt++;
    if (frame_err_a)  ferr_a_cnt++;
    if (overflow_b)   ovf_b_cnt++;
  end

  // ---------------- checker ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit glitch_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One PS/2 bit: data is set while the clock is high, then the clock is low
  // for 20 clk. With pop_b set, rd_en_b is high for exactly the cycle in
  // which the falling edge is detected inside the DUT.
  task automatic ps2_bit(input logic b, input bit pop_b);
    ps2_data = b;
    if (glitch_on) begin
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      @(negedge clk);
      ps2_clk = 1'b1;
      repeat (9) @(negedge clk);
    end else begin
      repeat (20) @(negedge clk);
    end
    ps2_clk = 1'b0;
    if (pop_b) begin
      repeat (EDGE_LAT) @(negedge clk);
      rd_en_b = 1'b1;
      @(negedge clk);
      rd_en_b = 1'b0;
      repeat (19 - EDGE_LAT) @(negedge clk);
    end else begin
      repeat (20) @(negedge clk);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input bit pop_b_at_push);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(1'b1, pop_b_at_push);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic pop_a();
    rd_en_a = 1'b1;
    @(negedge clk);
    rd_en_a = 1'b0;
  endtask

  task automatic pop_b();
    rd_en_b = 1'b1;
    @(negedge clk);
    rd_en_b = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic snap();
    perr_base = perr_a_cnt;
    ferr_base = ferr_a_cnt;
    ovf_base  = ovf_b_cnt;
  endtask

  // Frames 0x01..0x05 with hand-computed odd parity.
  logic [7:0] t5_data [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
  logic       t5_par  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rd_en_a  = 1'b0;
    rd_en_b  = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_valid", 32'(rd_valid_a), 32'd0);
    chk("rst_count", 32'(fifo_count_a), 32'd0);
    chk("rst_data",  32'(rd_data_a), 32'd0);
    chk("rst_errs",  32'({parity_err_a, frame_err_a, overflow_a}), 32'd0);
    chk("rst_state", 32'(dbg_state_a), 32'd0);

    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: single good frame 0x1C (P=0)
    snap();
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("t1_valid", 32'(rd_valid_a), 32'd1);
    chk("t1_data",  32'(rd_data_a), 32'h1C);
    chk("t1_count", 32'(fifo_count_a), 32'd1);
    chk("t1_perr",  32'(perr_a_cnt - perr_base), 32'd0);
    chk("t1_ferr",  32'(ferr_a_cnt - ferr_base), 32'd0);
    pop_a();
    chk("t1_empty", 32'(rd_valid_a), 32'd0);

    // 2: two frames read back in order
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("t2_count", 32'(fifo_count_a), 32'd2);
    chk("t2_head0", 32'(rd_data_a), 32'hF0);
    pop_a();
    chk("t2_head1", 32'(rd_data_a), 32'h1C);
    pop_a();
    chk("t2_valid", 32'(rd_valid_a), 32'd0);
    chk("t2_cnt0",  32'(fifo_count_a), 32'd0);

    // 3: parity error, then a good 0x5A (P=1)
    snap();
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("t3_perr",  32'(perr_a_cnt - perr_base), 32'd1);
    chk("t3_ferr",  32'(ferr_a_cnt - ferr_base), 32'd0);
    chk("t3_count", 32'(fifo_count_a), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("t3_data",  32'(rd_data_a), 32'h5A);
    chk("t3_valid", 32'(rd_valid_a), 32'd1);
    pop_a();

    // 4: start + 3 data bits, then a stalled bus -> timeout
    snap();
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    chk("t4_busy",  32'(dbg_state_a), 32'd1);
    repeat (TIMEOUT_CYC + 10) @(negedge clk);
    chk("t4_ferr",  32'(ferr_a_cnt - ferr_base), 32'd1);
    chk("t4_perr",  32'(perr_a_cnt - perr_base), 32'd0);
    chk("t4_idle",  32'(dbg_state_a), 32'd0);
    chk("t4_count", 32'(fifo_count_a), 32'd0);
    send_frame(8'h29, 1'b0, 1'b0);
    chk("t4_data",  32'(rd_data_a), 32'h29);
    chk("t4_cnt1",  32'(fifo_count_a), 32'd1);

    // 5: overflow on the depth-4 instance
    pulse_reset();
    snap();
    for (int i = 0; i < 4; i++) send_frame(t5_data[i], t5_par[i], 1'b0);
    chk("t5_noovf4", 32'(ovf_b_cnt - ovf_base), 32'd0);
    chk("t5_full",   32'(fifo_count_b), 32'd4);
    send_frame(t5_data[4], t5_par[4], 1'b0);
    chk("t5_ovf",    32'(ovf_b_cnt - ovf_base), 32'd1);
    chk("t5_cnt",    32'(fifo_count_b), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_rd%0d", i), 32'(rd_data_b), 32'(i + 1));
      pop_b();
    end
    chk("t5_empty",  32'(rd_valid_b), 32'd0);

    snap();
    for (int i = 0; i < 4; i++) send_frame(t5_data[i], t5_par[i], 1'b0);
    send_frame(t5_data[4], t5_par[4], 1'b1);
    chk("t5b_noovf", 32'(ovf_b_cnt - ovf_base), 32'd0);
    chk("t5b_cnt",   32'(fifo_count_b), 32'd4);
    chk("t5b_head",  32'(rd_data_b), 32'h02);

    // 6: reset in the middle of a frame
    pulse_reset();
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("t6_pre",    32'(fifo_count_a), 32'd1);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_valid",  32'(rd_valid_a), 32'd0);
    chk("t6_count",  32'(fifo_count_a), 32'd0);
    chk("t6_data",   32'(rd_data_a), 32'd0);
    chk("t6_state",  32'(dbg_state_a), 32'd0);
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    snap();
`ifdef PS2_GLITCH_FILTER_EN
    glitch_on = 1'b1;
`endif
    send_frame(8'h1C, 1'b0, 1'b0);
    glitch_on = 1'b0;
    chk("t6_rx",     32'(rd_data_a), 32'h1C);
    chk("t6_cnt1",   32'(fifo_count_a), 32'd1);
    chk("t6_noerr",  32'((perr_a_cnt - perr_base) + (ferr_a_cnt - ferr_base)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
